// File: rtl/int_to_fp_seq.sv
// Multi-cycle integer to IEEE-754 single converter.
// Normalises one bit per clock, then rounds in a single cycle.
module int_to_fp_seq #(
  parameter bit SIGNED = 1'b1,
  parameter bit RNE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [31:0] mag;
  logic [7:0]  expo;
  logic        sign;

  logic        neg;
  logic [31:0] abs_in;
  logic [22:0] mant;
  logic        grd;
  logic        stk;
  logic        inc;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;

  assign neg    = SIGNED & in_data[31];
  assign abs_in = neg ? (~in_data + 32'd1) : in_data;

  // 0x80000000 negates to itself, which is the correct magnitude
  assign mant   = mag[30:8];
  assign grd    = mag[7];
  assign stk    = |mag[6:0];
  assign inc    = RNE_EN & grd & (stk | mant[0]);
  assign mant_r = {1'b0, mant} + {23'd0, inc};
  assign exp_r  = expo + {7'd0, mant_r[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) nxt = NORM;
      end
      NORM: begin
        if (mag == 32'd0)  nxt = DONE;
        else if (mag[31])  nxt = ROUND;
      end
      ROUND: nxt = DONE;
      DONE: begin
        if (out_ready) nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = rst_n & (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag       <= 32'd0;
      expo      <= 8'd0;
      sign      <= 1'b0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= neg;
            mag  <= abs_in;
            expo <= 8'd158;
          end
        end
        NORM: begin
          if (mag == 32'd0) begin
            out_data  <= 32'd0;
            out_valid <= 1'b1;
          end else if (!mag[31]) begin
            mag  <= mag << 1;
            expo <= expo - 8'd1;
          end
        end
        ROUND: begin
          out_data  <= {sign, exp_r, mant_r[22:0]};
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
